// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC of the single-cycle MIPS datapath.
// It addresses the instruction memory, computes sequential and beq targets,
// and stops on the halt word (HALT) or on an unaligned or out-of-range PC (FAULT).
// fetch_valid gates every datapath commit.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | after reset; PC held until start
//   RUN   | one instruction per cycle; pause freezes PC
//   HALT  | halt word fetched; PC holds its address (absorbing)
//   FAULT | PC unaligned or past end of imem; PC holds it (absorbing)
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int unsigned IMEM_BYTES = 56
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic [31:0] instruction,
  input  logic        branch_taken,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  // Highest byte address at which a full word can still be fetched.
  localparam logic [31:0] PC_LAST   = 32'(IMEM_BYTES - 4);
  localparam logic [31:0] HALT_WORD = 32'hffff_ffff;
  localparam logic [5:0]  OP_BEQ    = 6'b000100;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] retired_q;

  logic        is_halt;
  logic        is_beq;
  logic        pc_bad;
  logic [31:0] branch_off;
  logic [31:0] pc_seq;
  logic [31:0] pc_branch;
  logic [31:0] pc_next;
  logic        unused_instr_bits;

  // Instruction decode and next-PC arithmetic, all 32-bit modulo 2^32.
  // A wrapped target is not trapped here; it shows up as pc_bad next cycle.
  always_comb begin
    is_halt    = (instruction == HALT_WORD);
    is_beq     = (instruction[31:26] == OP_BEQ);
    pc_bad     = (pc_q[1:0] != 2'b00) || (pc_q > PC_LAST);
    branch_off = {{14{instruction[15]}}, instruction[15:0], 2'b00};
    pc_seq     = pc_q + 32'd4;
    pc_branch  = pc_seq + branch_off;
    pc_next    = (is_beq && branch_taken) ? pc_branch : pc_seq;
  end

  // Register fields of the instruction word play no part in sequencing.
  assign unused_instr_bits = ^instruction[25:16];

  // State register; reset dominates every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. While paused the halt and fault checks are suspended.
  // pc_bad is tested before is_halt so a bad PC never reports as a halt.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!pause) begin
          if (pc_bad)       state_d = ST_FAULT;
          else if (is_halt) state_d = ST_HALT;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode: commit strobe and status flags.
  always_comb begin
    fetch_valid = (state_q == ST_RUN) && !pause && !pc_bad && !is_halt;
    halted      = (state_q == ST_HALT);
    fault       = (state_q == ST_FAULT);
  end

  // PC and retired counter advance only on a committing cycle; retired saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      retired_q <= 32'd0;
    end else if (fetch_valid) begin
      pc_q <= pc_next;
      if (retired_q != 32'hffff_ffff) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  assign pc      = pc_q;
  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed program and corner cases plus random stimulus,
// all checked cycle by cycle against a rule-level reference model.
module tb_pc_sequencer;

  localparam int IMEM_BYTES = 56;
  localparam logic [31:0] NOP = 32'h0041_1020;
  localparam logic [1:0] M_IDLE = 2'b00, M_RUN = 2'b01, M_HALT = 2'b10, M_FAULT = 2'b11;

  logic        clk = 1'b0;
  logic        reset, start, pause, branch_taken;
  logic [31:0] instruction;
  logic [31:0] pc, retired;
  logic        fetch_valid, halted, fault;
  logic [1:0]  state;

  logic [31:0] imem [14];
  bit          use_imem;
  logic [31:0] instr_drv;

  logic [31:0] m_pc, m_ret;
  logic [1:0]  m_state;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer #(.RESET_PC(32'd0), .IMEM_BYTES(IMEM_BYTES)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause),
    .instruction(instruction), .branch_taken(branch_taken),
    .pc(pc), .fetch_valid(fetch_valid), .halted(halted), .fault(fault),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a[1:0] == 2'b00 && a < 32'(IMEM_BYTES)) return imem[int'(a >> 2)];
    return 32'h0;
  endfunction

  always_comb begin
    instruction = instr_drv;
    if (use_imem) instruction = imem_word(pc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare all outputs with the model, then advance the model across one edge.
  task automatic step();
    logic [31:0] mi;
    bit bad, hlt, fv_e;
    longint off;
    #1;
    mi   = use_imem ? imem_word(m_pc) : instr_drv;
    bad  = (m_pc % 4 != 0) || (m_pc > 32'(IMEM_BYTES - 4));
    hlt  = (mi == 32'hffffffff);
    fv_e = (m_state == M_RUN) && !pause && !bad && !hlt;
    check("pc", pc, m_pc);
    check("state", 32'(state), 32'(m_state));
    check("retired", retired, m_ret);
    check("fetch_valid", 32'(fetch_valid), 32'(fv_e));
    check("halted", 32'(halted), 32'(m_state == M_HALT));
    check("fault", 32'(fault), 32'(m_state == M_FAULT));
    if (reset) begin
      m_pc = 32'd0; m_state = M_IDLE; m_ret = 32'd0;
    end else if (m_state == M_IDLE) begin
      if (start) m_state = M_RUN;
    end else if (m_state == M_RUN && !pause) begin
      if (bad) m_state = M_FAULT;
      else if (hlt) m_state = M_HALT;
      else begin
        off = 0;
        if (mi[31:26] == 6'd4 && branch_taken) off = 4 * longint'($signed(mi[15:0]));
        m_pc = 32'(longint'(m_pc) + 4 + off);
        if (m_ret != 32'hffffffff) m_ret = m_ret + 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; pause = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic run_to(input logic [31:0] target);
    use_imem = 1'b0; instr_drv = NOP; pause = 1'b0; start = 1'b1;
    for (int n = 0; n < 64 && m_pc != target; n++) begin
      branch_taken = 1'($urandom_range(0, 1));
      step();
    end
    check("reach_pc", pc, target);
  endtask

  initial begin
    int visits20;
    logic [15:0] offs;
    int r;
    // Program: beq at 20 loops back to 12 once, beq at 32 skips to the halt at 48.
    for (int i = 0; i < 14; i++) imem[i] = NOP;
    imem[5]  = 32'h1000fffd;
    imem[8]  = 32'h10000003;
    imem[12] = 32'hffffffff;

    use_imem = 1'b0; instr_drv = NOP; branch_taken = 1'b0;
    reset = 1'b1; start = 1'b0; pause = 1'b0;
    @(posedge clk); @(negedge clk);
    m_pc = 32'd0; m_state = M_IDLE; m_ret = 32'd0;

    // Standard program.
    step();
    reset = 1'b0; start = 1'b1; use_imem = 1'b1; visits20 = 0;
    for (int n = 0; n < 40 && m_state != M_HALT; n++) begin
      branch_taken = (m_pc == 32'd20 && visits20 == 0) || (m_pc == 32'd32);
      if (m_pc == 32'd20 && m_state == M_RUN) visits20++;
      step();
    end
    check("prog_state", 32'(state), 32'(M_HALT));
    check("prog_pc", pc, 32'd48);
    check("prog_retired", retired, 32'd12);
    check("prog_halted", 32'(halted), 32'd1);
    start = 1'b1; step();
    check("halt_absorb", 32'(state), 32'(M_HALT));

    // Backward branch from 40 to 20.
    do_reset(); run_to(32'd40);
    instr_drv = 32'h1000fffa; branch_taken = 1'b1; step();
    check("bb_pc", pc, 32'd20);
    check("bb_retired", retired, 32'd11);

    // beq not taken, then non-beq with branch_taken high.
    do_reset(); run_to(32'd32);
    instr_drv = 32'h10a00003; branch_taken = 1'b0; step();
    check("beq_nt_pc", pc, 32'd36);
    instr_drv = 32'h00411020; branch_taken = 1'b1; step();
    check("nonbeq_pc", pc, 32'd40);

    // Pause for three cycles at 12.
    do_reset(); run_to(32'd12);
    r = int'(retired);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("pause_pc", pc, 32'd12);
      check("pause_fv", 32'(fetch_valid), 32'd0);
      check("pause_ret", retired, 32'(r));
    end
    pause = 1'b0; instr_drv = NOP; step();
    check("unpause_pc", pc, 32'd16);

    // Branch out of range: 8 + 4 + 64 = 76.
    do_reset(); run_to(32'd8);
    instr_drv = 32'h10000010; branch_taken = 1'b1; step();
    check("fault_pc_target", pc, 32'd76);
    step();
    check("fault_state", 32'(state), 32'(M_FAULT));
    check("fault_flag", 32'(fault), 32'd1);
    check("fault_pc", pc, 32'd76);
    start = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("fault_absorb", 32'(state), 32'(M_FAULT));
    do_reset();
    check("fault_rst_state", 32'(state), 32'(M_IDLE));
    check("fault_rst_pc", pc, 32'd0);

    // Reset in the middle of RUN.
    do_reset(); run_to(32'd24);
    do_reset();
    check("midrst_pc", pc, 32'd0);
    check("midrst_state", 32'(state), 32'(M_IDLE));
    check("midrst_ret", retired, 32'd0);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_fv", 32'(fetch_valid), 32'd0);
    end

    // Random stimulus.
    use_imem = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      reset        = ($urandom_range(0, 19) == 0);
      start        = 1'($urandom_range(0, 1));
      pause        = ($urandom_range(0, 3) == 0);
      branch_taken = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        offs = 16'($urandom_range(0, 16)) - 16'd8;
        instr_drv = {6'b000100, 10'($urandom), offs};
      end else if (r == 4) begin
        instr_drv = 32'hffffffff;
      end else begin
        instr_drv = $urandom;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter controller for the single-cycle MIPS datapath. Owns the PC register that addresses the byte-wide instruction memory. Computes sequential and branch next-PC values, detects the halt word `0xffffffff`, and gates datapath commits through `fetch_valid`. Sits between the instruction-memory fetch block (drives its `address`, consumes its `instruction`) and the datapath control (consumes `branch_taken`, produces `fetch_valid`).

## Interface
- `RESET_PC`, default 0: PC value loaded on reset; byte address.
- `IMEM_BYTES`, default 56: size of instruction memory in bytes; must be a multiple of 4.
- `clk` in 1: sole clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level; leaves IDLE when high.
- `pause` in 1: level; freezes the PC while in RUN.
- `instruction` in 32: word fetched at current `pc` (combinational from instruction memory).
- `branch_taken` in 1: datapath beq comparison result (rs == rt) for the current instruction.
- `pc` out 32: current PC; drives instruction-memory `address`.
- `fetch_valid` out 1: current instruction commits this cycle; gates register and data-memory writes.
- `halted` out 1: high in HALT state.
- `fault` out 1: high in FAULT state.
- `state` out 2: IDLE=00, RUN=01, HALT=10, FAULT=11.
- `retired` out 32: count of committed instructions.

## Operation
- Reset: `pc`=RESET_PC, state=IDLE, `retired`=0. Resulting outputs: `fetch_valid`=0, `halted`=0, `fault`=0. Reset wins over every other input in the same cycle.
- Combinational decode:
  - `is_halt` = (`instruction` == 32'hffffffff).
  - `is_beq` = (`instruction[31:26]` == 6'b000100).
  - `pc_bad` = (`pc[1:0]` != 0) or (`pc` > IMEM_BYTES-4), evaluated as 32-bit unsigned.
- `fetch_valid` = (state==RUN) & ~`pause` & ~`pc_bad` & ~`is_halt`.
- Next PC when `fetch_valid`:
  - Branch: if `is_beq` & `branch_taken`, next PC = `pc` + 4 + (sign-extended `instruction[15:0]` << 2).
  - Otherwise next PC = `pc` + 4.
  - All arithmetic is 32-bit modulo 2^32. Wrap-around is not trapped at compute time; it is caught as `pc_bad` on the following cycle.
- `branch_taken` is ignored when `is_beq` is 0.
- State transitions:
  - IDLE: `start` → RUN. `pc` is held.
  - RUN, `pause`=1: hold `pc` and state. No commit. Halt and fault checks are suspended.
  - RUN, `pc_bad`: → FAULT. `pc` is held at the offending value. `pc_bad` has priority over `is_halt`.
  - RUN, `is_halt`: → HALT. `pc` is held at the halt word address. The halt word is not counted in `retired`.
  - RUN, otherwise: update `pc` to next PC and increment `retired`. `retired` saturates at 32'hffffffff.
  - HALT and FAULT: absorbing. Only `reset` exits them; `start` is ignored.
- `start` while already in RUN has no effect.

## Timing
- Zero-latency fetch. The instruction at `pc` is decoded in the same cycle. `pc` updates on the edge that ends a cycle with `fetch_valid`=1.
- One instruction per cycle in RUN without pause. A taken branch costs no extra cycles.
- Entering RUN from IDLE takes one edge. The first commit occurs in the first cycle spent in RUN.
- `halted` and `fault` assert on the cycle after the detecting cycle, i.e. when the state register reaches HALT or FAULT. `fetch_valid` is already 0 in the detecting cycle.
- Mid-operation reset: the next edge restores `pc`=RESET_PC, state=IDLE, `retired`=0, regardless of `pause`, `start`, or current state.

## Test plan
- Reset then `start`=1 with the standard 14-word program, `branch_taken` driven by a bench model. Required: `pc` sequence 0,4,…,32. At 32 (beq, offset 3, taken) → 48. At 48 the halt word is fetched. Required final state: HALT, `pc`=48, `retired`=12.
- Backward branch: `pc`=40, `instruction`=32'h1000fffa, `branch_taken`=1. Required: next `pc`=20 and `retired` increments by 1.
- Beq not taken: `pc`=32, `instruction`=32'h10a00003, `branch_taken`=0. Required: next `pc`=36. Non-beq with `branch_taken`=1, e.g. 32'h00411020: required next `pc`=`pc`+4.
- Pause: assert `pause` for 3 cycles at `pc`=12. Required: `pc` stays 12, `fetch_valid`=0, `retired` unchanged. On release, `pc`=16 after one edge.
- Fault: branch to an out-of-range target, e.g. offset 16'h0010 at `pc`=8 giving target 76. Required: FAULT the next cycle with `pc`=76 and `fault`=1. Subsequent `start` has no effect; `reset` returns the block to IDLE with `pc`=0.
- Reset mid-RUN at `pc`=24. Required: next edge gives `pc`=0, state=00, `retired`=0, and `fetch_valid`=0 until `start` is asserted.
